// File: rtl/wb_pgas_mem_slave_pkg.sv
// Shared Wishbone definitions: cycle/burst type codes, slave FSM states and
// the burst beat address advance rule.
package wb_defs;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACK   = 2'd2,
    ST_BURST = 2'd3
  } wb_state_e;

  // Wrapping bursts only advance the low bits; the upper word index stays put.
  function automatic logic [31:0] burst_next(logic [31:0] idx, logic [1:0] bte);
    logic [31:0] nxt;
    nxt = idx;
    case (bte)
      BTE_WRAP4:  nxt[1:0] = idx[1:0] + 2'd1;
      BTE_WRAP8:  nxt[2:0] = idx[2:0] + 3'd1;
      BTE_WRAP16: nxt[3:0] = idx[3:0] + 4'd1;
      default:    nxt      = idx + 32'd1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/wb_pgas_mem_slave_if.sv
// Wishbone B4 bus bundle used by masters and benches talking to the PGAS
// memory slave.
interface wb_pgas_mem_slave_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output adr, dat_w, sel, cti, bte, cyc, stb, we,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  adr, dat_w, sel, cti, bte, cyc, stb, we,
    output dat_r, ack, err, rty
  );
endinterface

// File: rtl/wb_pgas_mem_slave_sram.sv
// Word-organised storage with one byte-enabled write port and one
// asynchronous read port. Contents are never reset.
module wb_sram_array #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_pgas_mem_slave.sv
// Wishbone B4 memory slave for one PGAS window: classic cycles with a fixed
// wait count, incrementing bursts with linear/wrap addressing, err on a miss.
module wb_pgas_mem_slave
  import wb_defs::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o
);

  localparam int          AW = ADDR_WIDTH;
  localparam logic [3:0]  WS = 4'(WAIT_STATES);

  wb_state_e     state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          err_q, err_d;

  logic          req, hit, ack;
  logic [AW-1:0] adr_idx;
  logic [31:0]   idx_nxt;
  logic [31:0]   rdata;
  logic          unused_adr;

  assign req        = wb_cyc_i & wb_stb_i;
  assign hit        = (wb_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign adr_idx    = wb_adr_i[AW+1:2];
  assign unused_adr = ^wb_adr_i[1:0];
  assign idx_nxt    = burst_next({{(32-AW){1'b0}}, idx_q}, wb_bte_i);

  // ack follows stb combinationally so a master stall in a burst costs no beat
  assign ack = req & ((state_q == ST_ACK) | (state_q == ST_BURST));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!err_q && req) begin
          if (hit) begin
            idx_d = adr_idx;
            if (WS == 4'd0) begin
              state_d = ST_ACK;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = WS;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_ACK;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        if (req) begin
          if (wb_cti_i == CTI_INCR) begin
            state_d = ST_BURST;
            idx_d   = idx_nxt[AW-1:0];
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_BURST: begin
        if (req) begin
          idx_d = idx_nxt[AW-1:0];
          if (wb_cti_i == CTI_EOB) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!wb_cyc_i) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  wb_sram_array #(.AW(AW)) u_sram (
    .clk   (clk),
    .we    (ack & wb_we_i),
    .be    (wb_sel_i),
    .waddr (idx_q),
    .wdata (wb_dat_i),
    .raddr (idx_q),
    .rdata (rdata)
  );

  assign wb_ack_o = ack;
  assign wb_err_o = err_q & req & (state_q == ST_IDLE);
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = (ack & ~wb_we_i) ? rdata : 32'd0;

endmodule

// File: doc/wb_pgas_mem_slave.md
WB_PGAS_MEM_SLAVE -- requirements
Module: wb_pgas_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, giving the word-address width of the local memory (2^ADDR_WIDTH x 32-bit words).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte base address of the memory window.
REQ-003 SHALL have parameter WAIT_STATES, default 1, legal range 0..15, giving the extra cycles before the first ack.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port wb_adr_i, input, 32 bits: byte address.
REQ-008 SHALL have ports wb_cyc_i, wb_stb_i and wb_we_i, inputs, 1 bit each: bus cycle, strobe and write enable.
REQ-009 SHALL have ports wb_dat_i, input, 32 bits, and wb_sel_i, input, 4 bits: write data and byte lanes.
REQ-010 SHALL have ports wb_cti_i, input, 3 bits, and wb_bte_i, input, 2 bits: cycle type and burst type.
REQ-011 SHALL have port wb_dat_o, output, 32 bits: read data.
REQ-012 SHALL have ports wb_ack_o, wb_err_o and wb_rty_o, outputs, 1 bit each: acknowledge, error and retry.

Function
REQ-013 SHALL treat a request as present when wb_cyc_i & wb_stb_i, and as a hit when wb_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]; adr[1:0] ignored; word index = adr[ADDR_WIDTH+1:2].
REQ-014 SHALL use the FSM states IDLE, WAIT, ACK and BURST.
REQ-015 SHALL, for a miss sampled in IDLE, assert wb_err_o for exactly one cycle in the next cycle, with no memory access, then return to IDLE.
REQ-016 SHALL, for a hit first sampled in IDLE at cycle N, assert wb_ack_o in cycle N+1+WAIT_STATES, passing through WAIT while the wait counter is nonzero.
REQ-017 SHALL, on an ack cycle with wb_we_i=1, write the bytes of wb_dat_i enabled by wb_sel_i to the current word at the closing clock edge; wb_sel_i=0 writes nothing.
REQ-018 SHALL, on an ack cycle with wb_we_i=0, drive wb_dat_o with the word at the current address (all 4 bytes, regardless of wb_sel_i).
REQ-019 SHALL, when the ack cycle has wb_cti_i of 000, 001 or 111, keep ack high for one cycle, then return to IDLE with ack low for at least one cycle.
REQ-020 SHALL, when the ack cycle has wb_cti_i=010, enter BURST and ack every subsequent cycle in which cyc & stb are high (zero wait states between beats).
REQ-021 SHALL, in BURST, hold ack low while stb is low (master wait) and resume on the next stb, without skipping or repeating addresses.
REQ-022 SHALL compute the burst beat address internally: bte 00 linear (word index mod 2^ADDR_WIDTH), 01 wrap low 2 bits, 10 wrap low 3 bits, 11 wrap low 4 bits.
REQ-023 SHALL, in BURST, ack a beat with cti=111 and then return to IDLE.
REQ-024 SHALL, if wb_cyc_i drops in any state, return to IDLE at the next edge with no ack, no err and no write.
REQ-025 SHALL tie wb_rty_o to 0.
REQ-026 SHALL never assert wb_ack_o and wb_err_o together.
REQ-027 SHALL assert ack/err only while cyc & stb is high.

Reset
REQ-028 SHALL, while rst_n=0, force wb_ack_o=0, wb_err_o=0, wb_dat_o=0, FSM=IDLE and wait counter=0 asynchronously, including mid-burst.
REQ-029 SHALL leave memory contents unaffected by reset.
REQ-030 SHALL, after rst_n deasserts, accept a new request from the first following edge.

Structure
REQ-031 SHALL take the CTI codes (000, 001, 010, 111), BTE codes and FSM state encodings from the shared package wb_defs.
REQ-032 SHALL hold storage in one sub-module, wb_sram_array, with one byte-enabled write port and one read port.

Verification
REQ-033 SHALL cover: WAIT_STATES=1, classic write 0xDEADBEEF to 0x10, sel=1111, then read 0x10 -> ack in the 2nd cycle after request; read returns 0xDEADBEEF.
REQ-034 SHALL cover: write 0x11223344 to 0x20 with sel=0101, the word previously 0 -> read 0x20 returns 0x00220044.
REQ-035 SHALL cover: incrementing burst read at 0x38, bte=01, 4 beats (last with cti=111) -> word addresses 0x0E,0x0F,0x0C,0x0D, acks back-to-back after the first.
REQ-036 SHALL cover: BASE_ADDR=0, ADDR_WIDTH=10, access to 0x1000 -> one-cycle err, no ack, memory unchanged.
REQ-037 SHALL cover: burst with stb low for 2 cycles at beat 2 -> ack low for 2 cycles, beat 3 data from the next address.
REQ-038 SHALL cover: rst_n pulsed low mid-burst -> ack low immediately; after release a classic read completes normally.
